// File: rtl/riscv_branch_predictor_if.sv
// riscv_branch_predictor_if
//   Bundles the fetch-stage lookup, execute-stage resolution/training and
//   statistics signals of the dynamic branch predictor.
//   master : pipeline side (drives F/E stage inputs, consumes predictions)
//   slave  : predictor side
//   Signals:
//     i_bp_pc_f            fetch PC
//     o_bp_taken_f         predicted taken for the fetch PC
//     o_bp_next_pc_f       predicted next PC
//     i_bp_valid_e         real instruction in E
//     i_bp_ctrl_e          E instruction is branch/JAL/JALR
//     i_bp_is_branch_e     E instruction is a conditional branch
//     i_bp_pc_e            PC of E instruction
//     i_bp_actual_taken_e  resolved direction
//     i_bp_actual_target_e resolved target
//     i_bp_pred_taken_e    prediction made in F, piped to E
//     i_bp_pred_target_e   predicted next PC, piped to E
//     o_bp_mispredict_e    redirect required
//     o_bp_redirect_pc_e   correct next PC
//     o_bp_num_branch      resolved control instructions (saturating)
//     o_bp_num_mispredict  mispredicts (saturating)
interface riscv_branch_predictor_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] i_bp_pc_f;
    logic            o_bp_taken_f;
    logic [XLEN-1:0] o_bp_next_pc_f;
    logic            i_bp_valid_e;
    logic            i_bp_ctrl_e;
    logic            i_bp_is_branch_e;
    logic [XLEN-1:0] i_bp_pc_e;
    logic            i_bp_actual_taken_e;
    logic [XLEN-1:0] i_bp_actual_target_e;
    logic            i_bp_pred_taken_e;
    logic [XLEN-1:0] i_bp_pred_target_e;
    logic            o_bp_mispredict_e;
    logic [XLEN-1:0] o_bp_redirect_pc_e;
    logic [31:0]     o_bp_num_branch;
    logic [31:0]     o_bp_num_mispredict;

    modport master (
        output i_bp_pc_f,
        output i_bp_valid_e,
        output i_bp_ctrl_e,
        output i_bp_is_branch_e,
        output i_bp_pc_e,
        output i_bp_actual_taken_e,
        output i_bp_actual_target_e,
        output i_bp_pred_taken_e,
        output i_bp_pred_target_e,
        input  o_bp_taken_f,
        input  o_bp_next_pc_f,
        input  o_bp_mispredict_e,
        input  o_bp_redirect_pc_e,
        input  o_bp_num_branch,
        input  o_bp_num_mispredict
    );

    modport slave (
        input  i_bp_pc_f,
        input  i_bp_valid_e,
        input  i_bp_ctrl_e,
        input  i_bp_is_branch_e,
        input  i_bp_pc_e,
        input  i_bp_actual_taken_e,
        input  i_bp_actual_target_e,
        input  i_bp_pred_taken_e,
        input  i_bp_pred_target_e,
        output o_bp_taken_f,
        output o_bp_next_pc_f,
        output o_bp_mispredict_e,
        output o_bp_redirect_pc_e,
        output o_bp_num_branch,
        output o_bp_num_mispredict
    );
endinterface

// File: rtl/riscv_branch_predictor.sv
// riscv_branch_predictor
//   Direct-mapped branch target buffer with 2-bit saturating direction
//   counters for the RV32I 5-stage pipeline. F stage looks up the next PC
//   combinationally; E stage gets a combinational mispredict flag and the
//   corrected PC, and trains the table at the rising edge. Saturating
//   statistics counters report resolved control instructions and mispredicts.
//   Ports:
//     i_clk  clock, all state updates on the rising edge
//     i_rst  asynchronous active-high reset
//     bp     predictor side of riscv_branch_predictor_if
module riscv_branch_predictor #(
    parameter int         XLEN     = 32,
    parameter int         N_ENTRY  = 16,
    parameter logic [1:0] CNT_INIT = 2'b01
) (
    input logic                     i_clk,
    input logic                     i_rst,
    riscv_branch_predictor_if.slave bp
);

    localparam int IDX   = $clog2(N_ENTRY);
    localparam int TAG_W = XLEN - IDX - 2;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    // Saturating 2-bit direction counter training.
    function automatic logic [1:0] cnt_train(input logic [1:0] c, input logic taken);
        logic [1:0] r;
        if (taken) begin
            r = (c == 2'b11) ? c : c + 2'b01;
        end else begin
            r = (c == 2'b00) ? c : c - 2'b01;
        end
        return r;
    endfunction

    // Saturating statistics increment.
    function automatic logic [31:0] stat_inc(input logic [31:0] s, input logic en);
        logic [31:0] r;
        if (en && (s != 32'hFFFF_FFFF)) begin
            r = s + 32'd1;
        end else begin
            r = s;
        end
        return r;
    endfunction

    logic             valid_q  [N_ENTRY];
    logic [TAG_W-1:0] tag_q    [N_ENTRY];
    logic [XLEN-1:0]  target_q [N_ENTRY];
    logic [1:0]       cnt_q    [N_ENTRY];
    logic [31:0]      num_branch_q;
    logic [31:0]      num_mispredict_q;

    // ---- F stage lookup ----
    logic [IDX-1:0]   idx_f;
    logic [TAG_W-1:0] tag_f;
    logic             hit_f;
    logic             taken_f;

    assign idx_f   = bp.i_bp_pc_f[IDX+1:2];
    assign tag_f   = bp.i_bp_pc_f[XLEN-1:IDX+2];
    assign hit_f   = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    assign taken_f = hit_f && cnt_q[idx_f][1];

    assign bp.o_bp_taken_f   = taken_f;
    assign bp.o_bp_next_pc_f = taken_f ? target_q[idx_f] : bp.i_bp_pc_f + PC_STEP;

    // ---- E stage resolution ----
    logic [IDX-1:0]   idx_e;
    logic [TAG_W-1:0] tag_e;
    logic             tag_match_e;
    logic             hit_e;
    logic             eff_taken_e;
    logic             mispredict_e;
    logic             upd_e;
    logic             inval_e;
    logic [1:0]       cnt_next_e;

    assign idx_e       = bp.i_bp_pc_e[IDX+1:2];
    assign tag_e       = bp.i_bp_pc_e[XLEN-1:IDX+2];
    assign tag_match_e = (tag_q[idx_e] == tag_e);
    assign hit_e       = valid_q[idx_e] && tag_match_e;
    // Non-control instructions never redirect to a target, even if the
    // actual_taken input happens to be set.
    assign eff_taken_e = bp.i_bp_ctrl_e && bp.i_bp_actual_taken_e;

    always_comb begin
        mispredict_e = 1'b0;
        if (bp.i_bp_valid_e) begin
            if (bp.i_bp_ctrl_e) begin
                mispredict_e = (bp.i_bp_pred_taken_e != bp.i_bp_actual_taken_e) ||
                               (bp.i_bp_actual_taken_e &&
                                (bp.i_bp_pred_target_e != bp.i_bp_actual_target_e));
            end else begin
                // A non-control instruction predicted taken hit a stale
                // aliased entry; fetch must fall back to pc+4.
                mispredict_e = bp.i_bp_pred_taken_e;
            end
        end
    end

    assign bp.o_bp_mispredict_e  = mispredict_e;
    assign bp.o_bp_redirect_pc_e = eff_taken_e ? bp.i_bp_actual_target_e
                                               : bp.i_bp_pc_e + PC_STEP;

    assign upd_e   = bp.i_bp_valid_e && bp.i_bp_ctrl_e;
    // Invalidation depends only on the tag; clearing an already-invalid
    // entry is harmless.
    assign inval_e = bp.i_bp_valid_e && !bp.i_bp_ctrl_e && bp.i_bp_pred_taken_e &&
                     tag_match_e;

    always_comb begin
        cnt_next_e = CNT_INIT;
        if (!bp.i_bp_is_branch_e) begin
            // Unconditional jumps are always taken: start strongly taken.
            cnt_next_e = 2'b11;
        end else if (hit_e) begin
            cnt_next_e = cnt_train(cnt_q[idx_e], bp.i_bp_actual_taken_e);
        end else begin
            cnt_next_e = bp.i_bp_actual_taken_e ? 2'b10 : CNT_INIT;
        end
    end

    // ---- table and statistics state ----
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < N_ENTRY; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= CNT_INIT;
            end
            num_branch_q     <= '0;
            num_mispredict_q <= '0;
        end else begin
            if (upd_e) begin
                valid_q[idx_e]  <= 1'b1;
                tag_q[idx_e]    <= tag_e;
                target_q[idx_e] <= bp.i_bp_actual_target_e;
                cnt_q[idx_e]    <= cnt_next_e;
            end else if (inval_e) begin
                valid_q[idx_e] <= 1'b0;
            end
            num_branch_q     <= stat_inc(num_branch_q, upd_e);
            num_mispredict_q <= stat_inc(num_mispredict_q, mispredict_e);
        end
    end

    assign bp.o_bp_num_branch     = num_branch_q;
    assign bp.o_bp_num_mispredict = num_mispredict_q;

endmodule

// File: tb/tb_riscv_branch_predictor.sv
// Directed testbench for riscv_branch_predictor (N_ENTRY = 16).
module tb_riscv_branch_predictor;

    typedef enum logic [2:0] {K_TAKEN, K_NEXT, K_MISP, K_REDIR, K_NB, K_NM} kind_e;
    typedef struct {
        kind_e       k;
        logic [31:0] v;
        string       name;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t sb[$];

    riscv_branch_predictor_if #(.XLEN(32)) bpif ();

    riscv_branch_predictor #(
        .XLEN(32),
        .N_ENTRY(16),
        .CNT_INIT(2'b01)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bp(bpif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic push_exp(input kind_e k, input logic [31:0] v, input string name);
        exp_t e;
        e.k = k;
        e.v = v;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        logic [31:0] obs;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.k)
                K_TAKEN: obs = {31'd0, bpif.o_bp_taken_f};
                K_NEXT:  obs = bpif.o_bp_next_pc_f;
                K_MISP:  obs = {31'd0, bpif.o_bp_mispredict_e};
                K_REDIR: obs = bpif.o_bp_redirect_pc_e;
                K_NB:    obs = bpif.o_bp_num_branch;
                default: obs = bpif.o_bp_num_mispredict;
            endcase
            checks++;
            assert (obs === e.v) else begin
                errors++;
                $error("FAIL %s observed %h expected %h", e.name, obs, e.v);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_e(input logic v, input logic ctrl, input logic isbr,
                         input logic [31:0] pc, input logic at, input logic [31:0] atgt,
                         input logic pt, input logic [31:0] ptgt);
        bpif.i_bp_valid_e         = v;
        bpif.i_bp_ctrl_e          = ctrl;
        bpif.i_bp_is_branch_e     = isbr;
        bpif.i_bp_pc_e            = pc;
        bpif.i_bp_actual_taken_e  = at;
        bpif.i_bp_actual_target_e = atgt;
        bpif.i_bp_pred_taken_e    = pt;
        bpif.i_bp_pred_target_e   = ptgt;
    endtask

    task automatic idle_e();
        set_e(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic exp_f(input logic tk, input logic [31:0] nxt, input string name);
        push_exp(K_TAKEN, {31'd0, tk}, {name, "_taken"});
        push_exp(K_NEXT, nxt, {name, "_next"});
    endtask

    task automatic exp_e(input logic m, input logic [31:0] r, input string name);
        push_exp(K_MISP, {31'd0, m}, {name, "_misp"});
        push_exp(K_REDIR, r, {name, "_redir"});
    endtask

    task automatic exp_s(input logic [31:0] nb, input logic [31:0] nm, input string name);
        push_exp(K_NB, nb, {name, "_nbr"});
        push_exp(K_NM, nm, {name, "_nmis"});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bpif.i_bp_pc_f = 32'h100;
        idle_e();
        @(negedge clk);

        // Reset state
        exp_f(1'b0, 32'h104, "rst_lookup");
        exp_s(32'd0, 32'd0, "rst_stats");
        exp_e(1'b0, 32'h4, "rst_e");
        check();
        rst = 1'b0;
        @(negedge clk);

        // First taken branch at 0x100 -> 0x80; lookup same cycle sees old contents
        set_e(1, 1, 1, 32'h100, 1, 32'h80, 0, 32'h104);
        exp_f(1'b0, 32'h104, "alloc_nobypass");
        exp_e(1'b1, 32'h80, "alloc");
        check();
        tick();
        idle_e();
        exp_f(1'b1, 32'h80, "after_alloc");
        exp_s(32'd1, 32'd1, "after_alloc");
        check();

        // Correct taken prediction: 10 -> 11
        set_e(1, 1, 1, 32'h100, 1, 32'h80, 1, 32'h80);
        exp_e(1'b0, 32'h80, "taken_ok");
        check();
        tick();

        // Not-taken: 11 -> 10, still predicts taken
        set_e(1, 1, 1, 32'h100, 0, 32'h80, 1, 32'h80);
        exp_e(1'b1, 32'h104, "nt1");
        check();
        tick();
        idle_e();
        exp_f(1'b1, 32'h80, "after_nt1");
        exp_s(32'd3, 32'd2, "after_nt1");
        check();

        // Second not-taken: 10 -> 01, predicts not taken
        set_e(1, 1, 1, 32'h100, 0, 32'h80, 1, 32'h80);
        exp_e(1'b1, 32'h104, "nt2");
        check();
        tick();
        idle_e();
        exp_f(1'b0, 32'h104, "after_nt2");
        exp_s(32'd4, 32'd3, "after_nt2");
        check();

        // Taken again from 01 -> 10 (hit, so trained rather than reallocated)
        set_e(1, 1, 1, 32'h100, 1, 32'h80, 0, 32'h104);
        exp_e(1'b1, 32'h80, "retrain");
        check();
        tick();
        idle_e();
        exp_f(1'b1, 32'h80, "after_retrain");
        check();

        // Aliased PC with same index, different tag misses
        bpif.i_bp_pc_f = 32'h140;
        exp_f(1'b0, 32'h144, "alias_miss");
        check();
        bpif.i_bp_pc_f = 32'h100;

        // Non-control at 0x100 predicted taken: flush and invalidate
        set_e(1, 0, 0, 32'h100, 1, 32'h80, 1, 32'h80);
        exp_e(1'b1, 32'h104, "nonctrl");
        check();
        tick();
        idle_e();
        exp_f(1'b0, 32'h104, "after_inval");
        exp_s(32'd5, 32'd5, "after_inval");
        check();

        // JALR at 0x200 -> 0x300 installs strongly taken
        bpif.i_bp_pc_f = 32'h200;
        set_e(1, 1, 0, 32'h200, 1, 32'h300, 0, 32'h204);
        exp_e(1'b1, 32'h300, "jalr1");
        check();
        tick();
        idle_e();
        exp_f(1'b1, 32'h300, "after_jalr1");
        check();

        // JALR target changes to 0x400
        set_e(1, 1, 0, 32'h200, 1, 32'h400, 1, 32'h300);
        exp_e(1'b1, 32'h400, "jalr2");
        check();
        tick();
        idle_e();
        exp_f(1'b1, 32'h400, "after_jalr2");
        exp_s(32'd7, 32'd7, "after_jalr2");
        check();

        // Bubble in E: no mispredict, no training, no stats
        set_e(0, 1, 1, 32'h200, 0, 32'h500, 1, 32'h500);
        exp_e(1'b0, 32'h204, "bubble");
        check();
        tick();
        idle_e();
        exp_f(1'b1, 32'h400, "after_bubble");
        exp_s(32'd7, 32'd7, "after_bubble");
        check();

        // Correct JALR prediction counts a branch but not a mispredict
        set_e(1, 1, 0, 32'h200, 1, 32'h400, 1, 32'h400);
        exp_e(1'b0, 32'h400, "jalr_ok");
        check();
        tick();
        idle_e();
        exp_s(32'd8, 32'd7, "after_jalr_ok");
        check();

        // pc+4 wraps at the top of the address space
        bpif.i_bp_pc_f = 32'hFFFF_FFFC;
        set_e(1, 0, 0, 32'hFFFF_FFFC, 0, 32'h0, 0, 32'h0);
        exp_f(1'b0, 32'h0, "wrap_f");
        exp_e(1'b0, 32'h0, "wrap_e");
        check();
        tick();
        idle_e();
        bpif.i_bp_pc_f = 32'h200;

        // Asynchronous reset between edges
        set_e(1, 1, 1, 32'h100, 1, 32'h80, 0, 32'h104);
        #2;
        rst = 1'b1;
        exp_f(1'b0, 32'h204, "async_rst");
        exp_s(32'd0, 32'd0, "async_rst");
        exp_e(1'b1, 32'h80, "async_rst");
        check();
        idle_e();
        rst = 1'b0;
        @(negedge clk);

        // Statistics saturation
        force dut.num_branch_q = 32'hFFFF_FFFF;
        force dut.num_mispredict_q = 32'hFFFF_FFFF;
        #1;
        release dut.num_branch_q;
        release dut.num_mispredict_q;
        exp_s(32'hFFFF_FFFF, 32'hFFFF_FFFF, "preload");
        check();
        set_e(1, 1, 1, 32'h100, 1, 32'h80, 0, 32'h104);
        exp_e(1'b1, 32'h80, "sat_misp");
        check();
        tick();
        idle_e();
        exp_s(32'hFFFF_FFFF, 32'hFFFF_FFFF, "saturate");
        check();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
